// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time-setting controller.
// Holds field ranges and widths, edit_field codes, the FSM state encoding
// and a wrap-around step helper for the minute/second fields.
package time_pkg;

  localparam int HOUR_MAX = 24;
  localparam int MIN_MAX  = 60;
  localparam int SEC_MAX  = 60;

  localparam int HOUR_W = 5;
  localparam int MIN_W  = 6;
  localparam int SEC_W  = 6;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  typedef enum logic [2:0] {
    RUN,
    SET_HOUR,
    SET_MIN,
    SET_SEC,
    COMMIT
  } state_e;

  // One step up or down inside [0, max-1], wrapping at both ends.
  function automatic logic [5:0] step_wrap(input logic [5:0] v,
                                           input logic [5:0] max,
                                           input logic       up);
    if (up) return (v == max - 6'd1) ? '0 : v + 6'd1;
    else    return (v == '0) ? max - 6'd1 : v - 6'd1;
  endfunction

endpackage

// File: rtl/time_set_ctrl_blink_gen.sv
// Blink divider for the field under edit.
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   restart   - forces blink_on=1 and restarts the half-period count
//   enable    - counting allowed; when low the counter is held at 0, blink_on=1
//   blink_on  - toggles every HALF_PERIOD enabled cycles
module blink_gen #(
  parameter int unsigned HALF_PERIOD = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic blink_on
);

  localparam int unsigned CW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart || !enable) begin
      cnt      <= '0;
      blink_on <= 1'b1;
    end else if (cnt == CW'(HALF_PERIOD - 1)) begin
      cnt      <= '0;
      blink_on <= ~blink_on;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/time_set_ctrl.sv
// Time-setting controller for a time-of-day clock.
// Captures the live time on key_mode, lets the user step hour/min/sec with
// key_inc/key_dec, and issues a single load_en pulse after the seconds field.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   key_mode/key_inc/key_dec    - debounced single-cycle key pulses
//   cur_hour/cur_min/cur_sec    - live time from the time-of-day counter
//   load_en, load_hour/min/sec  - one-cycle load command and the time to load
//   disp_hour/min/sec           - values for the display driver
//   edit_field                  - 0=none, 1=hour, 2=min, 3=sec
//   blink_on                    - display enable for the field under edit
// Build option: define TIME_SET_TIMEOUT_EN to abort an edit after
// CLK_FREQ*TIMEOUT_S cycles without any key pulse.
module time_set_ctrl
  import time_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BLINK_HZ  = 2,
  parameter int unsigned TIMEOUT_S = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              key_mode,
  input  logic              key_inc,
  input  logic              key_dec,
  input  logic [HOUR_W-1:0] cur_hour,
  input  logic [MIN_W-1:0]  cur_min,
  input  logic [SEC_W-1:0]  cur_sec,
  output logic              load_en,
  output logic [HOUR_W-1:0] load_hour,
  output logic [MIN_W-1:0]  load_min,
  output logic [SEC_W-1:0]  load_sec,
  output logic [HOUR_W-1:0] disp_hour,
  output logic [MIN_W-1:0]  disp_min,
  output logic [SEC_W-1:0]  disp_sec,
  output logic [1:0]        edit_field,
  output logic              blink_on
);

  localparam int unsigned BLINK_RAW  = (BLINK_HZ == 0) ? 1 : CLK_FREQ / (2 * BLINK_HZ);
  localparam int unsigned BLINK_HALF = (BLINK_RAW == 0) ? 1 : BLINK_RAW;

  state_e            state;
  logic [HOUR_W-1:0] edit_hour, hour_step;
  logic [MIN_W-1:0]  edit_min, min_step;
  logic [SEC_W-1:0]  edit_sec, sec_step;
  logic              in_set, any_key, adjust, idle_expired;

  assign in_set  = (state == SET_HOUR) || (state == SET_MIN) || (state == SET_SEC);
  assign any_key = key_mode | key_inc | key_dec;
  // inc together with dec cancels out
  assign adjust  = key_inc ^ key_dec;

`ifdef TIME_SET_TIMEOUT_EN
  localparam int unsigned IDLE_RAW   = CLK_FREQ * TIMEOUT_S;
  localparam int unsigned IDLE_LIMIT = (IDLE_RAW == 0) ? 1 : IDLE_RAW;
  localparam int unsigned IW         = (IDLE_LIMIT > 1) ? $clog2(IDLE_LIMIT) : 1;

  logic [IW-1:0] idle_cnt;

  assign idle_expired = in_set && !any_key && (idle_cnt == IW'(IDLE_LIMIT - 1));

  always_ff @(posedge clk) begin
    if (rst || !in_set || any_key || idle_expired) idle_cnt <= '0;
    else                                            idle_cnt <= idle_cnt + 1'b1;
  end
`else
  assign idle_expired = 1'b0;
  // TIMEOUT_S has no effect in this build.
  if (TIMEOUT_S == 0) begin : g_timeout_unused
  end
`endif

  always_comb begin
    hour_step = key_inc ? ((edit_hour == 5'(HOUR_MAX - 1)) ? '0 : edit_hour + 1'b1)
                        : ((edit_hour == '0) ? 5'(HOUR_MAX - 1) : edit_hour - 1'b1);
    min_step  = step_wrap(edit_min, 6'(MIN_MAX), key_inc);
    sec_step  = step_wrap(edit_sec, 6'(SEC_MAX), key_inc);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      edit_hour <= '0;
      edit_min  <= '0;
      edit_sec  <= '0;
    end else begin
      unique case (state)
        RUN: begin
          if (key_mode) begin
            edit_hour <= (cur_hour < 5'(HOUR_MAX)) ? cur_hour : '0;
            edit_min  <= (cur_min  < 6'(MIN_MAX))  ? cur_min  : '0;
            edit_sec  <= (cur_sec  < 6'(SEC_MAX))  ? cur_sec  : '0;
            state     <= SET_HOUR;
          end
        end
        SET_HOUR: begin
          if (key_mode)          state     <= SET_MIN;
          else if (adjust)       edit_hour <= hour_step;
          else if (idle_expired) state     <= RUN;
        end
        SET_MIN: begin
          if (key_mode)          state    <= SET_SEC;
          else if (adjust)       edit_min <= min_step;
          else if (idle_expired) state    <= RUN;
        end
        SET_SEC: begin
          if (key_mode)          state    <= COMMIT;
          else if (adjust)       edit_sec <= sec_step;
          else if (idle_expired) state    <= RUN;
        end
        COMMIT:  state <= RUN;
        default: state <= RUN;
      endcase
    end
  end

  always_comb begin
    load_en    = (state == COMMIT);
    load_hour  = edit_hour;
    load_min   = edit_min;
    load_sec   = edit_sec;
    disp_hour  = (state == RUN) ? cur_hour : edit_hour;
    disp_min   = (state == RUN) ? cur_min  : edit_min;
    disp_sec   = (state == RUN) ? cur_sec  : edit_sec;
    edit_field = FIELD_NONE;
    case (state)
      SET_HOUR: edit_field = FIELD_HOUR;
      SET_MIN:  edit_field = FIELD_MIN;
      SET_SEC:  edit_field = FIELD_SEC;
      default:  edit_field = FIELD_NONE;
    endcase
  end

  // A timeout exit restarts the divider so RUN starts with blink_on=1.
  blink_gen #(
    .HALF_PERIOD(BLINK_HALF)
  ) u_blink (
    .clk     (clk),
    .rst     (rst),
    .restart (any_key | idle_expired),
    .enable  (in_set),
    .blink_on(blink_on)
  );

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl (CLK_FREQ=100, BLINK_HZ=5, TIMEOUT_S=2).
module tb_time_set_ctrl;

  localparam int HALF = 10;   // 100 / (2*5)
  localparam int IDLE = 200;  // 100 * 2

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0, key_inc = 1'b0, key_dec = 1'b0;
  logic [4:0] cur_hour = 5'd12;
  logic [5:0] cur_min = 6'd34, cur_sec = 6'd56;
  logic       load_en, blink_on;
  logic [4:0] load_hour, disp_hour;
  logic [5:0] load_min, load_sec, disp_min, disp_sec;
  logic [1:0] edit_field;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  time_set_ctrl #(
    .CLK_FREQ (100),
    .BLINK_HZ (5),
    .TIMEOUT_S(2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .key_mode  (key_mode),
    .key_inc   (key_inc),
    .key_dec   (key_dec),
    .cur_hour  (cur_hour),
    .cur_min   (cur_min),
    .cur_sec   (cur_sec),
    .load_en   (load_en),
    .load_hour (load_hour),
    .load_min  (load_min),
    .load_sec  (load_sec),
    .disp_hour (disp_hour),
    .disp_min  (disp_min),
    .disp_sec  (disp_sec),
    .edit_field(edit_field),
    .blink_on  (blink_on)
  );

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Model: phase 0=run, 1..3=editing hour/min/sec, 4=load cycle.
  int m_phase, m_h, m_m, m_s, m_age, m_idle;
  bit m_valid = 1'b0;

  always @(posedge clk) begin : model
    int  np, d;
    bit  any;
    if (rst) begin
      m_phase = 0; m_h = 0; m_m = 0; m_s = 0; m_age = 0; m_idle = 0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      any = key_mode || key_inc || key_dec;
      np  = m_phase;
      d   = key_inc ? 1 : -1;
      case (m_phase)
        0: if (key_mode) begin
             m_h = (cur_hour < 24) ? int'(cur_hour) : 0;
             m_m = (cur_min  < 60) ? int'(cur_min)  : 0;
             m_s = (cur_sec  < 60) ? int'(cur_sec)  : 0;
             np  = 1;
           end
        1, 2, 3: begin
          if (key_mode) np = m_phase + 1;
          else if (key_inc != key_dec) begin
            if (m_phase == 1)      m_h = (m_h + d + 24) % 24;
            else if (m_phase == 2) m_m = (m_m + d + 60) % 60;
            else                   m_s = (m_s + d + 60) % 60;
          end
`ifdef TIME_SET_TIMEOUT_EN
          if (any) m_idle = 0;
          else begin
            m_idle++;
            if (m_idle == IDLE) np = 0;
          end
`endif
        end
        default: np = 0;
      endcase
      if (np >= 1 && np <= 3 && np == m_phase && !any) m_age++;
      else m_age = 0;
      if (np == 0 || np == 4 || any) m_idle = 0;
      m_phase = np;
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      bit editing;
      editing = (m_phase >= 1 && m_phase <= 3);
      check("cyc_edit_field", edit_field, editing ? m_phase : 0);
      check("cyc_load_en", load_en, (m_phase == 4) ? 1 : 0);
      check("cyc_disp_hour", disp_hour, (m_phase == 0) ? int'(cur_hour) : m_h);
      check("cyc_disp_min", disp_min, (m_phase == 0) ? int'(cur_min) : m_m);
      check("cyc_disp_sec", disp_sec, (m_phase == 0) ? int'(cur_sec) : m_s);
      check("cyc_blink", blink_on, editing ? (((m_age / HALF) % 2 == 0) ? 1 : 0) : 1);
      if (m_phase == 4) begin
        check("cyc_load_hour", load_hour, m_h);
        check("cyc_load_min", load_min, m_m);
        check("cyc_load_sec", load_sec, m_s);
      end
    end
  end

  task automatic pulse(input logic m, input logic i, input logic d);
    @(posedge clk); #2;
    key_mode = m; key_inc = i; key_dec = d;
    @(posedge clk); #2;
    key_mode = 1'b0; key_inc = 1'b0; key_dec = 1'b0;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    tick(2);
    rst = 1'b0;
    check("rst_edit_field", edit_field, 0);
    check("rst_load_en", load_en, 0);
    check("rst_blink", blink_on, 1);
    check("rst_disp_hour", disp_hour, 12);

    // Capture 12:34:56 and enter hour edit
    pulse(1, 0, 0);
    check("cap_field", edit_field, 1);
    check("cap_hour", disp_hour, 12);
    check("cap_min", disp_min, 34);
    check("cap_sec", disp_sec, 56);
    check("cap_blink", blink_on, 1);
    cur_hour = 5'd5; cur_min = 6'd6; cur_sec = 6'd7;
    tick(1);
    check("edit_ignores_cur", disp_hour, 12);

    // Hour wrap both ways
    repeat (11) pulse(0, 1, 0);
    check("hour_23", disp_hour, 23);
    pulse(0, 1, 0);
    check("hour_wrap_up", disp_hour, 0);
    pulse(0, 0, 1);
    pulse(0, 0, 1);
    check("hour_22", disp_hour, 22);

    // Minute wrap both ways
    pulse(1, 0, 0);
    check("min_field", edit_field, 2);
    repeat (26) pulse(0, 1, 0);
    check("min_wrap_up", disp_min, 0);
    pulse(0, 0, 1);
    check("min_wrap_down", disp_min, 59);

    // Seconds 56 -> 07, then inc+dec together
    pulse(1, 0, 0);
    check("sec_field", edit_field, 3);
    repeat (11) pulse(0, 1, 0);
    check("sec_07", disp_sec, 7);
    pulse(0, 1, 1);
    check("inc_dec_cancel", disp_sec, 7);

    // key_mode with key_inc: transition only, then single load cycle
    pulse(1, 1, 0);
    check("commit_load_en", load_en, 1);
    check("commit_hour", load_hour, 22);
    check("commit_min", load_min, 59);
    check("commit_sec", load_sec, 7);
    tick(1);
    check("after_commit_load_en", load_en, 0);
    check("after_commit_field", edit_field, 0);
    check("after_commit_disp", disp_hour, 5);

    // Out-of-range capture clamps to 0
    cur_hour = 5'd30; cur_min = 6'd61; cur_sec = 6'd63;
    pulse(1, 0, 0);
    check("clamp_hour", disp_hour, 0);
    check("clamp_min", disp_min, 0);
    check("clamp_sec", disp_sec, 0);
    pulse(0, 1, 0);
    pulse(1, 0, 1);
    check("mode_dec_field", edit_field, 2);
    check("mode_dec_hour", disp_hour, 1);
    check("mode_dec_min", disp_min, 0);

    // Blink period in SET_MIN with no keys
    tick(9);
    check("blink_age9", blink_on, 1);
    tick(1);
    check("blink_age10", blink_on, 0);
    tick(10);
    check("blink_age20", blink_on, 1);

`ifdef TIME_SET_TIMEOUT_EN
    tick(179);
    check("idle_199_field", edit_field, 2);
    tick(1);
    check("timeout_field", edit_field, 0);
    check("timeout_load_en", load_en, 0);
`else
    tick(230);
    check("no_timeout_field", edit_field, 2);
    pulse(1, 0, 0);
    pulse(1, 0, 0);
    check("late_commit", load_en, 1);
    check("late_commit_hour", load_hour, 1);
    tick(1);
`endif

    // Reset during SET_SEC
    cur_hour = 5'd12; cur_min = 6'd34; cur_sec = 6'd56;
    repeat (3) pulse(1, 0, 0);
    check("pre_rst_field", edit_field, 3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_set_field", edit_field, 0);
    check("rst_set_load", load_en, 0);
    check("rst_set_disp", disp_hour, 12);

    // Reset during COMMIT
    repeat (4) pulse(1, 0, 0);
    check("pre_rst_commit", load_en, 1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rst_commit_load", load_en, 0);
    check("rst_commit_field", edit_field, 0);
    tick(3);
    check("rst_commit_idle_load", load_en, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/time_set_ctrl.md
TIME_SET_CTRL -- requirements
Module: time_set_ctrl

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50_000_000, clock frequency in Hz.
REQ-002 SHALL have parameter BLINK_HZ, default 2, blink toggle pairs per second.
REQ-003 SHALL have parameter TIMEOUT_S, default 10, inactivity seconds before edit abort (used only when TIMEOUT_EN is defined).
REQ-004 SHALL have port clk, input, 1, system clock; one clock domain only.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port key_mode, input, 1, debounced single-cycle pulse that advances the edit field.
REQ-007 SHALL have port key_inc, input, 1, debounced single-cycle pulse that increments the field.
REQ-008 SHALL have port key_dec, input, 1, debounced single-cycle pulse that decrements the field.
REQ-009 SHALL have ports cur_hour / cur_min / cur_sec, input, 5/6/6, live time from the time-of-day counter.
REQ-010 SHALL have output load_en, 1, single-cycle pulse commanding the counter to load the new time.
REQ-011 SHALL have outputs load_hour / load_min / load_sec, 5/6/6, time to load; valid when load_en=1.
REQ-012 SHALL have outputs disp_hour / disp_min / disp_sec, 5/6/6, values for the display driver.
REQ-013 SHALL have output edit_field, 2, field under edit: 0=none, 1=hour, 2=min, 3=sec.
REQ-014 SHALL have output blink_on, 1, display enable for the field under edit (1=visible).

Function
REQ-015 SHALL implement FSM states RUN, SET_HOUR, SET_MIN, SET_SEC, COMMIT.
REQ-016 RUN: disp_* SHALL equal cur_* combinationally; edit_field=0; key_inc/key_dec ignored.
REQ-017 RUN + key_mode SHALL capture cur_* into edit registers in the same cycle and go to SET_HOUR next cycle.
REQ-018 key_mode SHALL advance SET_HOUR->SET_MIN->SET_SEC->COMMIT.
REQ-019 COMMIT SHALL last exactly one cycle with load_en=1 and load_*=edit registers, then return to RUN; load_en SHALL be 0 in all other states.
REQ-020 SET_* states: disp_* SHALL equal the edit registers; edit_field SHALL be 1/2/3 respectively.
REQ-021 key_inc SHALL add 1 to the active field, wrapping hour 23->0 and min/sec 59->0; key_dec SHALL subtract 1, wrapping hour 0->23 and min/sec 0->59; the new value SHALL appear on disp_* the next cycle.
REQ-022 key_inc and key_dec asserted together SHALL leave the field unchanged.
REQ-023 key_mode asserted with key_inc or key_dec SHALL perform the transition only; the field is unchanged.
REQ-024 Edit registers SHALL never hold out-of-range values; captured cur_* values out of range SHALL be clamped to 0.
REQ-025 In SET_* states, blink_on SHALL toggle every CLK_FREQ/(2*BLINK_HZ) cycles; any key pulse or state entry SHALL force blink_on=1 and restart the blink counter.
REQ-026 In RUN and COMMIT, blink_on SHALL be 1 and the blink counter SHALL be held at 0.

Reset
REQ-027 rst=1 at a clock edge SHALL set state=RUN, load_en=0, edit registers=0, blink_on=1, and all internal counters=0.
REQ-028 rst during a SET_* state SHALL discard the edit with no load_en pulse; rst during COMMIT SHALL suppress load_en in the following cycle.

Configuration
REQ-029 Macro TIME_SET_TIMEOUT_EN defined: in SET_* states, CLK_FREQ*TIMEOUT_S consecutive cycles without any key pulse SHALL return the FSM to RUN without asserting load_en; any key pulse SHALL clear the inactivity counter.
REQ-030 Macro TIME_SET_TIMEOUT_EN undefined: there SHALL be no inactivity counter, and SET_* states SHALL persist until key_mode or rst.

Structure
REQ-031 Shared package time_pkg SHALL hold HOUR_MAX=24, MIN_MAX=60, SEC_MAX=60, the field width constants, the edit_field codes and the FSM state encoding.
REQ-032 The blink divider SHALL be a separate sub-module blink_gen (inputs: clk, rst, restart, enable; output: blink_on).

Verification (sim with CLK_FREQ=100, BLINK_HZ=5, TIMEOUT_S=2)
REQ-033 cur=12:34:56, pulse key_mode ->; next cycle edit_field=1, disp=12:34:56, blink_on=1.
REQ-034 In SET_HOUR with hour=23, pulse key_inc -> hour=0; pulse key_dec twice -> hour=22; in SET_MIN with min=0, pulse key_dec -> min=59.
REQ-035 Pulse key_mode x3 from SET_HOUR with edit 22:59:07 -> exactly one load_en cycle with load=22:59:07, then edit_field=0.
REQ-036 Pulse key_inc and key_dec in the same cycle -> field unchanged; key_mode with key_inc -> field advances, value unchanged.
REQ-037 With no keys in SET_MIN -> blink_on toggles every 10 cycles; with TIMEOUT_EN, after 200 idle cycles -> RUN and no load_en.
REQ-038 rst in SET_SEC and rst in the COMMIT cycle -> state RUN and load_en=0 on the next cycle.
